// File: rtl/cpu_parameters.sv
// cpu_parameters: shared core widths and writeback enums
package cpu_parameters;
    localparam int XLEN = 32;
    typedef enum logic {RUN, TRAP} wb_state_e;
    typedef enum logic {SRC_ALU, SRC_MEM} wb_src_e;
endpackage

// File: rtl/intirvx_wb_arb.sv
// intirvx_wb_arb: two-input round-robin grant between ALU and memory results
module intirvx_wb_arb
    import cpu_parameters::*;
(
    input  logic    alu_valid_i,
    input  logic    mem_valid_i,
    input  wb_src_e last_grant_i,
    output wb_src_e grant_o
);
    // on a tie favour whichever source was not served last
    always_comb begin
        grant_o = (alu_valid_i && mem_valid_i) ? ((last_grant_i == SRC_ALU) ? SRC_MEM : SRC_ALU)
                                               : (mem_valid_i ? SRC_MEM : SRC_ALU);
    end
endmodule

// File: rtl/intirvx_wb.sv
// intirvx_wb: writeback stage merging ALU/memory results into the register file with trap handling
module intirvx_wb
    import cpu_parameters::*;
#(
    parameter int RET_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [4:0]       alu_rd,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [XLEN-1:0]  mem_res,
    input  logic             mem_exception,
    input  logic [4:0]       mem_rd,
    input  logic             mem_valid,
    output logic             mem_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             sb_clear,
    output logic [4:0]       sb_clear_rd,
    output logic             trap_valid,
    output logic [4:0]       trap_rd,
    input  logic             trap_ack,
    output logic             flush,
    output logic [RET_W-1:0] minstret
);
    wb_state_e        state_q, state_d;
    wb_src_e          last_grant_q, last_grant_d, grant;
    logic             rf_we_q, rf_we_d, sb_clear_q, sb_clear_d, flush_q, flush_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d, sb_clear_rd_q, sb_clear_rd_d, trap_rd_q, trap_rd_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [RET_W-1:0] minstret_q, minstret_d;
    logic             hs, exc, run;
    logic [4:0]       rd;
    logic [XLEN-1:0]  res;

    intirvx_wb_arb u_arb (
        .alu_valid_i  (alu_valid),
        .mem_valid_i  (mem_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // handshake decode, FSM next state and registered-output next values
    always_comb begin
        run           = state_q == RUN;
        alu_ready     = run && grant == SRC_ALU;
        mem_ready     = run && grant == SRC_MEM;
        hs            = (alu_valid && alu_ready) || (mem_valid && mem_ready);
        exc           = mem_valid && mem_ready && mem_exception;
        rd            = (grant == SRC_MEM) ? mem_rd : alu_rd;
        res           = (grant == SRC_MEM) ? mem_res : alu_res;
        state_d       = exc ? TRAP : ((!run && trap_ack) ? RUN : state_q);
        last_grant_d  = hs ? grant : last_grant_q;
        rf_we_d       = hs && !exc && rd != 5'd0;
        rf_waddr_d    = hs ? rd : rf_waddr_q;
        rf_wdata_d    = hs ? res : rf_wdata_q;
        sb_clear_d    = hs && rd != 5'd0;
        sb_clear_rd_d = hs ? rd : sb_clear_rd_q;
        flush_d       = exc;
        trap_rd_d     = exc ? mem_rd : trap_rd_q;
        minstret_d    = minstret_q + RET_W'(hs && !exc);
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            last_grant_q  <= SRC_ALU;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            sb_clear_q    <= 1'b0;
            sb_clear_rd_q <= '0;
            flush_q       <= 1'b0;
            trap_rd_q     <= '0;
            minstret_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            sb_clear_q    <= sb_clear_d;
            sb_clear_rd_q <= sb_clear_rd_d;
            flush_q       <= flush_d;
            trap_rd_q     <= trap_rd_d;
            minstret_q    <= minstret_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign sb_clear    = sb_clear_q;
    assign sb_clear_rd = sb_clear_rd_q;
    assign flush       = flush_q;
    assign trap_rd     = trap_rd_q;
    assign trap_valid  = state_q == TRAP;
    assign minstret    = minstret_q;
endmodule

// File: tb/tb_intirvx_wb.sv
// tb_intirvx_wb: directed self-checking bench for the writeback stage
module tb_intirvx_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_res = '0, mem_res = '0, rf_wdata;
    logic [4:0]  alu_rd = '0, mem_rd = '0, rf_waddr, sb_clear_rd, trap_rd;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, mem_exception = 1'b0, trap_ack = 1'b0;
    logic        alu_ready, mem_ready, rf_we, sb_clear, trap_valid, flush;
    logic [63:0] minstret;
    int          n_cmp = 0, n_bad = 0;

    intirvx_wb #(.RET_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_res(alu_res), .alu_rd(alu_rd), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .mem_res(mem_res), .mem_exception(mem_exception), .mem_rd(mem_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_clear(sb_clear), .sb_clear_rd(sb_clear_rd),
        .trap_valid(trap_valid), .trap_rd(trap_rd), .trap_ack(trap_ack),
        .flush(flush), .minstret(minstret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_rd [4];
        logic       exp_alu_rdy [4];
        exp_rd      = '{5'd2, 5'd1, 5'd2, 5'd1};
        exp_alu_rdy = '{1'b0, 1'b1, 1'b0, 1'b1};

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_sb_clear", sb_clear, 0);
        chk("rst_flush", flush, 0);
        chk("rst_trap_valid", trap_valid, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_minstret", minstret, 0);
        rst_n = 1'b1;

        // single ALU result
        @(negedge clk);
        alu_valid = 1'b1; alu_res = 32'h12345678; alu_rd = 5'd5;
        #1 chk("alu_ready", alu_ready, 1);
        @(negedge clk);
        chk("alu_rf_we", rf_we, 1);
        chk("alu_rf_waddr", rf_waddr, 5);
        chk("alu_rf_wdata", rf_wdata, 32'h12345678);
        chk("alu_sb_clear", sb_clear, 1);
        chk("alu_sb_clear_rd", sb_clear_rd, 5);
        chk("alu_minstret", minstret, 1);
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_rf_we_pulse", rf_we, 0);
        chk("alu_sb_clear_pulse", sb_clear, 0);

        // both sources valid for four cycles: MEM, ALU, MEM, ALU
        alu_valid = 1'b1; alu_rd = 5'd1; alu_res = 32'hA1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_res = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_alu_ready", alu_ready, exp_alu_rdy[i]);
            chk("rr_mem_ready", mem_ready, !exp_alu_rdy[i]);
            @(negedge clk);
            chk("rr_rf_waddr", rf_waddr, exp_rd[i]);
            chk("rr_rf_wdata", rf_wdata, exp_rd[i] == 5'd2 ? 32'hB2 : 32'hA1);
        end
        chk("rr_minstret", minstret, 5);

        // faulting memory access with an ALU result waiting
        alu_rd = 5'd3; alu_res = 32'h33;
        mem_rd = 5'd7; mem_res = 32'hDEAD; mem_exception = 1'b1;
        #1 chk("exc_mem_ready", mem_ready, 1);
        @(negedge clk);
        mem_valid = 1'b0; mem_exception = 1'b0;
        chk("exc_rf_we", rf_we, 0);
        chk("exc_sb_clear", sb_clear, 1);
        chk("exc_sb_clear_rd", sb_clear_rd, 7);
        chk("exc_flush", flush, 1);
        chk("exc_trap_valid", trap_valid, 1);
        chk("exc_trap_rd", trap_rd, 7);
        chk("exc_minstret", minstret, 5);
        #1 chk("exc_alu_ready", alu_ready, 0);
        @(negedge clk);
        chk("trap_flush_once", flush, 0);
        chk("trap_hold", trap_valid, 1);
        chk("trap_rf_we", rf_we, 0);
        chk("trap_alu_ready", alu_ready, 0);
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("ack_trap_valid", trap_valid, 0);
        #1 chk("ack_alu_ready", alu_ready, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("resume_rf_we", rf_we, 1);
        chk("resume_rf_waddr", rf_waddr, 3);
        chk("resume_rf_wdata", rf_wdata, 32'h33);
        chk("resume_minstret", minstret, 6);
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("ack_in_run", trap_valid, 0);

        // write to x0
        alu_valid = 1'b1; alu_rd = 5'd0; alu_res = 32'hFFFFFFFF;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("x0_rf_we", rf_we, 0);
        chk("x0_sb_clear", sb_clear, 0);
        chk("x0_minstret", minstret, 7);

        // minstret wrap
        force dut.minstret_q = '1;
        #1 release dut.minstret_q;
        chk("wrap_preload", minstret, 64'hFFFFFFFFFFFFFFFF);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_res = 32'h44;
        @(negedge clk);
        chk("wrap_minstret", minstret, 0);
        chk("wrap_rf_we", rf_we, 1);
        alu_rd = 5'd6; alu_res = 32'h66;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("pre_rst_minstret", minstret, 1);

        // asynchronous reset while trapped
        mem_valid = 1'b1; mem_exception = 1'b1; mem_rd = 5'd9;
        @(negedge clk);
        mem_valid = 1'b0; mem_exception = 1'b0;
        chk("rst_trap_entry", trap_valid, 1);
        chk("rst_trap_rd_set", trap_rd, 9);
        #2 rst_n = 1'b0;
        #1 chk("async_trap_valid", trap_valid, 0);
        chk("async_minstret", minstret, 0);
        chk("async_trap_rd", trap_rd, 0);
        chk("async_flush", flush, 0);
        chk("async_sb_clear", sb_clear, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rf_we", rf_we, 0);
        chk("post_rst_sb_clear", sb_clear, 0);
        chk("post_rst_flush", flush, 0);
        chk("post_rst_trap_valid", trap_valid, 0);
        #1 chk("post_rst_alu_ready", alu_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
